// File: rtl/fp_div_iter_if.sv
// Operand/result handshake bundle for fp_div_iter.
// master drives operands and consumes results; slave is the divider.
interface fp_div_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_div_iter.sv
// Multi-cycle floating-point divider, radix-2 restoring, one quotient bit
// per cycle. Flags = {invalid, div_zero, overflow, underflow}.
// Subnormal operands are read as signed zero; tiny results flush to zero.
// Optional: define FP_DIV_ROUND_NEAREST_EN for round-to-nearest-even;
// without it the quotient is truncated (round toward zero).
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         EN,
  fp_div_iter_if.slave io
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int XW = EXP_W + 2;          // signed working exponent
  localparam int MW = MAN_W + 1;          // mantissa with hidden bit
  localparam int QW = MAN_W + 3;          // quotient: 1 int + MAN_W+2 frac
  localparam int CW = $clog2(QW + 1);

  localparam logic [EXP_W-1:0]    EXP_ONES = '1;
  localparam logic [EXP_W-1:0]    EXP_ZERO = '0;
  localparam logic [MAN_W-1:0]    FRAC_0   = '0;
  localparam logic [MAN_W-2:0]    QNAN_LO  = '0;
  localparam logic signed [XW-1:0] XW_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_OVF = XW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
  localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, QNAN_LO};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d;
  logic                  sign_q, sign_d;
  logic signed [XW-1:0]  exp_q, exp_d;
  logic [MW-1:0]         mb_q, mb_d;
  logic [MW:0]           rem_q, rem_d;
  logic [QW-1:0]         quo_q, quo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          res_q, res_d;
  logic [3:0]            flg_q, flg_d;

  // operand field decode
  logic                  sa, sb;
  logic [EXP_W-1:0]      ea, eb;
  logic [MAN_W-1:0]      fa, fb;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign a_zero = (ea == EXP_ZERO);
  assign b_zero = (eb == EXP_ZERO);
  assign a_inf  = (ea == EXP_ONES) && (fa == FRAC_0);
  assign b_inf  = (eb == EXP_ONES) && (fb == FRAC_0);
  assign a_nan  = (ea == EXP_ONES) && (fa != FRAC_0);
  assign b_nan  = (eb == EXP_ONES) && (fb != FRAC_0);

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.result    = res_q;
  assign io.flags     = flg_q;

  // restoring step: trial subtract, keep on non-negative
  logic [MW+1:0] div_diff;
  logic          div_neg;
  assign div_diff = {1'b0, rem_q} - {2'b00, mb_q};
  assign div_neg  = div_diff[MW+1];

  // normalise, round and range-check the finished quotient
  logic [MAN_W-1:0]     norm_frac;
  logic signed [XW-1:0] norm_exp;
  logic                 norm_ovf, norm_unf;
  logic [W-1:0]         norm_res;
`ifdef FP_DIV_ROUND_NEAREST_EN
  logic                 rnd_guard, rnd_sticky, rnd_inc, rnd_carry;
`endif

  always_comb begin
    norm_frac = quo_q[QW-1] ? quo_q[QW-2:2] : quo_q[QW-3:1];
    norm_exp  = quo_q[QW-1] ? exp_q : exp_q - XW_ONE;
`ifdef FP_DIV_ROUND_NEAREST_EN
    rnd_guard  = quo_q[QW-1] ? quo_q[1] : quo_q[0];
    rnd_sticky = (quo_q[QW-1] & quo_q[0]) | (rem_q != '0);
    rnd_inc    = rnd_guard & (rnd_sticky | norm_frac[0]);
    {rnd_carry, norm_frac} = {1'b0, norm_frac} + {{MAN_W{1'b0}}, rnd_inc};
    // carry out means 1.111..+ulp = 10.000..; the wrapped fraction is already
    // the right-shifted value, so only the exponent moves
    if (rnd_carry) norm_exp = norm_exp + XW_ONE;
`endif
    norm_ovf = (norm_exp >= EXP_OVF);
    norm_unf = norm_exp[XW-1] | (norm_exp == '0);
    if (norm_ovf)      norm_res = {sign_q, EXP_ONES, FRAC_0};
    else if (norm_unf) norm_res = {sign_q, EXP_ZERO, FRAC_0};
    else               norm_res = {sign_q, norm_exp[EXP_W-1:0], norm_frac};
  end

  // control FSM next-state and datapath updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flg_d   = flg_q;
    case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          a_d     = io.A;
          b_d     = io.B;
          flg_d   = '0;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d  = sa ^ sb;
        exp_d   = XW'(ea) - XW'(eb) + XW'(BIAS);
        mb_d    = {1'b1, fb};
        rem_d   = {2'b01, fa};
        quo_d   = '0;
        cnt_d   = CW'(QW);
        state_d = S_DIVIDE;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          res_d    = QNAN;
          flg_d[3] = 1'b1;
          state_d  = S_DONE;
        end else if (b_zero && !a_inf) begin
          res_d    = {sa ^ sb, EXP_ONES, FRAC_0};
          flg_d[2] = 1'b1;
          state_d  = S_DONE;
        end else if (a_inf) begin
          res_d   = {sa ^ sb, EXP_ONES, FRAC_0};
          state_d = S_DONE;
        end else if (a_zero || b_inf) begin
          res_d   = {sa ^ sb, EXP_ZERO, FRAC_0};
          state_d = S_DONE;
        end
      end
      S_DIVIDE: begin
        rem_d = (div_neg ? rem_q : div_diff[MW:0]) << 1;
        quo_d = {quo_q[QW-2:0], ~div_neg};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_NORM;
      end
      S_NORM: begin
        res_d   = norm_res;
        flg_d   = {2'b00, norm_ovf, norm_unf};
        state_d = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers; EN low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mb_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else if (EN) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mb_q    <= mb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end
endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Parametrised, handshaked, multi-cycle IEEE-754-style floating-point divider. Successor to the single-precision combinational-style divider in the Floating ALU.
- Uses a radix-2 restoring mantissa divider: one quotient bit per cycle.
- valid/ready input and output handshakes; exponent/mantissa widths are generic.
- Reports status flags and handles special operands explicitly. Sits behind the Floating ALU operand mux.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: stored mantissa (fraction) width. Word width is W = 1+EXP_W+MAN_W.
- BIAS, 127: exponent bias. Must equal 2^(EXP_W-1)-1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- EN, input, 1: clock enable. When 0, all state is held and handshakes are ignored.
- in_valid, input, 1: operands A/B present.
- in_ready, output, 1: block can accept operands (state IDLE).
- A, input, W: dividend.
- B, input, W: divisor.
- out_valid, output, 1: result and flags valid.
- out_ready, input, 1: consumer accepts result.
- result, output, W: quotient.
- flags, output, 4: {invalid, div_zero, overflow, underflow}.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, all internal registers cleared. Reset mid-operation aborts the operation; no output is produced for it.
- Everything below applies only on edges with EN=1.
- States: IDLE, UNPACK, DIVIDE, NORM, DONE.
- IDLE: in_ready=1. in_valid=1 latches A and B, then goes to UNPACK.
- UNPACK:
  - Sign = sA^sB.
  - Exponent = eA-eB+BIAS, computed signed, EXP_W+2 bits.
  - Mantissas get the hidden 1 prepended.
  - Subnormal operands are treated as signed zero.
  - Special-case checks, in priority order:
    1. Either operand NaN, 0/0, or inf/inf: result=qNaN (sign 0, exponent all ones, fraction MSB=1, rest 0), invalid=1.
    2. Finite nonzero / 0: result=signed inf, div_zero=1.
    3. inf / finite: result=signed inf.
    4. 0 / nonzero, or finite / inf: result=signed zero.
  - A special case goes directly to DONE. Otherwise go to DIVIDE with the iteration counter set to MAN_W+3.
- DIVIDE:
  - Each cycle: trial remainder R-Mb. If the result is non-negative, keep it and shift in quotient bit 1; else shift in 0.
  - R then shifts left by 1. R starts at Ma.
  - Runs for MAN_W+3 cycles, producing quotient Q[MAN_W+2:0]. Q MSB has weight 2^0.
  - sticky = (final R != 0).
- NORM:
  - If Q MSB=0: shift Q left 1 and decrement the exponent.
  - Round (see Optional Feature). If rounding carries out of the mantissa, shift right 1 and increment the exponent.
  - exponent >= 2^EXP_W-1: result=signed inf, overflow=1.
  - exponent <= 0: result=signed zero (flush-to-zero), underflow=1.
  - Then go to DONE.
- DONE:
  - out_valid=1; result and flags are held stable.
  - out_ready=1 returns the block to IDLE with out_valid=0.
  - in_ready stays 0 in DONE. A new operand is not accepted on the same edge the result is taken.
- Latency counted from the accepting edge:
  - Normal operands: out_valid rises after MAN_W+5 edges (28 at default widths).
  - Special cases: out_valid rises after 1 edge.
  - Both figures exclude any EN=0 cycles.
- Flags are cleared when a new operand is accepted. Throughput is one operation in flight.

Optional Feature:
- Macro: FP_DIV_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even.
  - guard = bit below the LSB.
  - sticky = OR of the remaining bits and the remainder sticky.
  - Increment when guard & (sticky | LSB).
- Undefined: truncation (round toward zero). The guard and sticky hardware is omitted.

Test Plan:
- A=0x411C0000 (9.75), B=0x40800000 (4) -> result=0x401C0000, flags=0, out_valid exactly 28 edges after accept.
- A=0x41B26666 (22.3), B=0xBF000000 (-0.5) -> result=0xC2326666. A=0xC0CCCCCC (-6.4), B=0xBF000000 -> result=0x414CCCCC.
- Specials:
  - 0x00000000/0x411C0000 -> 0x00000000.
  - 0x7F800000/0x411C0000 -> 0x7F800000.
  - 0x3F800000/0x00000000 -> 0x7F800000 with div_zero.
  - 0/0 -> 0x7FC00000 with invalid.
  - Each produces out_valid 1 edge after accept.
- Overflow and underflow:
  - 0x7F000000/0x3E800000 -> 0x7F800000 with overflow.
  - 0x00800000/0x40000000 -> 0x00000000 with underflow.
- Rounding: 0x3F800000/0x40400000 -> 0x3EAAAAAB with FP_DIV_ROUND_NEAREST_EN defined, 0x3EAAAAAA without.
- Handshake and control:
  - Hold out_ready=0 for 10 cycles: result stays stable and in_ready stays 0.
  - Deassert EN mid-DIVIDE for 5 cycles: latency stretches by exactly 5.
  - Pull rst_n low mid-DIVIDE: out_valid=0 and in_ready=1 immediately, with no result emitted.
